// File: rtl/apb_multi_master.sv
// APB requester bridging a simple valid/ready command port onto up to 16
// address-decoded APB completers, with decode-error and timeout responses.
module apb_multi_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_SLV   = 16,
    parameter int SLV_SHIFT = 12,
    parameter int TIMEOUT   = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic                      penable,
    output logic [NUM_SLV-1:0]        psel,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen during the last ACCESS cycle allowed before abort
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;

    logic [ADDR_W-1:0]  cmd_region;
    logic               cmd_legal;
    logic [IDX_W-1:0]   cmd_idx;

    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;

    // Region number of the incoming command; anything past the last completer is a decode error
    assign cmd_region = cmd_addr >> SLV_SHIFT;
    assign cmd_legal  = (cmd_region < ADDR_W'(NUM_SLV));
    assign cmd_idx    = cmd_region[IDX_W-1:0];

    // Commands are only taken in IDLE, and never while reset is held
    assign cmd_ready  = (state == IDLE) && !preset;

    // Pick out the addressed completer's handshake and data; all others are ignored
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transfer sequencer: IDLE -> SETUP -> ACCESS, with registered APB and response outputs
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            penable     <= 1'b0;
            psel        <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_legal) begin
                            idx     <= cmd_idx;
                            paddr   <= cmd_addr;
                            pwrite  <= cmd_write;
                            pwdata  <= cmd_wdata;
                            psel    <= NUM_SLV'(1) << cmd_idx;
                            penable <= 1'b0;
                            cnt     <= '0;
                            state   <= SETUP;
                        end else begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= sel_err;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : sel_rdata;
                        state       <= IDLE;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_multi_master.sv
// Self-checking bench for apb_multi_master with four completers and a 16-cycle timeout.
// A transaction-level model predicts each cycle's outputs from command timing rules.
module tb_apb_multi_master;

    logic         pclk = 1'b0;
    logic         preset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [31:0]  cmd_addr;
    logic [31:0]  cmd_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         rsp_timeout;
    logic [31:0]  paddr;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic         penable;
    logic [3:0]   psel;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;

    int vectors = 0;
    int errors  = 0;

    apb_multi_master #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_SHIFT(12), .TIMEOUT(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .penable(penable),
        .psel(psel), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Free-running clock, 10 time units per cycle
    always #5 pclk = ~pclk;

    // Completer behaviour: selected completer waits wait_cfg ACCESS cycles; idle ones drive junk
    int          wait_cfg [4];
    logic        err_cfg  [4];
    logic [31:0] rdata_cfg[4];
    int          acc_cnt;

    always_comb begin
        pready  = '1;
        pslverr = '1;
        prdata  = '0;
        for (int i = 0; i < 4; i++) begin
            pready[i]           = psel[i] ? (penable && (acc_cnt >= wait_cfg[i])) : 1'b1;
            pslverr[i]          = psel[i] ? err_cfg[i] : 1'b1;
            prdata[i*32 +: 32]  = psel[i] ? rdata_cfg[i] : (32'hDEAD_0000 | 32'(i));
        end
    end

    // Count ACCESS cycles the selected completer has spent stalling
    always @(posedge pclk) begin
        if (penable && !(|(psel & pready)))
            acc_cnt <= acc_cnt + 1;
        else
            acc_cnt <= 0;
    end

    // Expected behaviour of one clock cycle
    typedef struct packed {
        logic        busy;
        logic [3:0]  sel;
        logic        pen;
        logic        rsp;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        logic        upd;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } rec_t;

    rec_t        q[$];
    logic [31:0] h_rdata, h_paddr, h_pwdata;
    logic        h_err, h_tmo, h_pwrite;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand an accepted command into the cycles it will occupy
    task automatic modelAccept();
        rec_t r;
        int   idx;
        int   n_acc;
        logic tmo;
        idx = int'(cmd_addr >> 12);
        r = '0;
        if (idx >= 4) begin
            r.rsp = 1'b1;
            r.err = 1'b1;
            q.push_back(r);
        end else begin
            tmo   = (wait_cfg[idx] >= 16);
            n_acc = tmo ? 16 : wait_cfg[idx] + 1;
            r.busy  = 1'b1;
            r.sel   = 4'(1 << idx);
            r.upd   = 1'b1;
            r.addr  = cmd_addr;
            r.wr    = cmd_write;
            r.wdata = cmd_wdata;
            q.push_back(r);
            r.upd = 1'b0;
            r.pen = 1'b1;
            for (int k = 0; k < n_acc; k++) q.push_back(r);
            r       = '0;
            r.rsp   = 1'b1;
            r.tmo   = tmo;
            r.err   = tmo ? 1'b1 : err_cfg[idx];
            r.rdata = (tmo || cmd_write) ? 32'h0 : rdata_cfg[idx];
            q.push_back(r);
        end
    endtask

    // Compare process: every cycle outside reset, check all outputs against the model
    initial begin
        rec_t r;
        forever begin
            @(negedge pclk);
            if (preset) begin
                q.delete();
                h_rdata = '0; h_err = 1'b0; h_tmo = 1'b0;
                h_paddr = '0; h_pwrite = 1'b0; h_pwdata = '0;
            end else begin
                r = (q.size() > 0) ? q.pop_front() : rec_t'(0);
                if (r.upd) begin
                    h_paddr = r.addr; h_pwrite = r.wr; h_pwdata = r.wdata;
                end
                if (r.rsp) begin
                    h_rdata = r.rdata; h_err = r.err; h_tmo = r.tmo;
                end
                checkOutput("cmd_ready",   32'(cmd_ready),   32'(!r.busy));
                checkOutput("psel",        32'(psel),        32'(r.sel));
                checkOutput("penable",     32'(penable),     32'(r.pen));
                checkOutput("rsp_valid",   32'(rsp_valid),   32'(r.rsp));
                checkOutput("rsp_rdata",   rsp_rdata,        h_rdata);
                checkOutput("rsp_err",     32'(rsp_err),     32'(h_err));
                checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(h_tmo));
                checkOutput("paddr",       paddr,            h_paddr);
                checkOutput("pwrite",      32'(pwrite),      32'(h_pwrite));
                checkOutput("pwdata",      pwdata,           h_pwdata);
                if (!r.busy && cmd_valid) modelAccept();
            end
        end
    end

    // Present a command and return once it is accepted (one time unit after the accepting edge)
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 output int waited);
        logic got;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        waited    = 0;
        got       = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge pclk);
            waited++;
            got = cmd_ready;
        end
        if (!got) checkOutput("accept_timeout", 32'(got), 32'h1);
        @(posedge pclk);
        #1;
    endtask

    // Wait for the response pulse, reporting latency, penable cycles and first-cycle psel
    task automatic waitResponse(output int lat, output int pen_cycles, output logic [3:0] first_psel);
        logic got;
        lat = 0; pen_cycles = 0; first_psel = '0; got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge pclk);
            lat++;
            if (lat == 1) first_psel = psel;
            if (penable) pen_cycles++;
            got = rsp_valid;
        end
        if (!got) checkOutput("response_timeout", 32'(got), 32'h1);
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         wt, lat, pc, nrsp;
        logic [3:0] fp;

        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0; err_cfg[i] = 1'b0; rdata_cfg[i] = 32'h1111_0000 + 32'(i);
        end
        repeat (2) @(posedge pclk);
        #1;
        checkOutput("reset_psel",      32'(psel),      32'h0);
        checkOutput("reset_penable",   32'(penable),   32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        checkOutput("reset_paddr",     paddr,          32'h0);
        preset = 1'b0;
        @(posedge pclk); #1;

        // Zero-wait read from completer 3
        rdata_cfg[3] = 32'hA5A5_0001;
        applyStimulus(1'b0, 32'h0000_3010, 32'h0, wt);
        cmd_valid = 1'b0;
        waitResponse(lat, pc, fp);
        checkOutput("zw_latency", 32'(lat), 32'd3);
        checkOutput("zw_psel",    32'(fp),  32'h8);
        checkOutput("zw_rdata",   rsp_rdata, 32'hA5A5_0001);
        checkOutput("zw_err",     32'(rsp_err), 32'h0);
        @(posedge pclk); #1;

        // Write with two wait states and a slave error
        wait_cfg[1] = 2; err_cfg[1] = 1'b1;
        applyStimulus(1'b1, 32'h0000_1000, 32'h0000_1234, wt);
        cmd_valid = 1'b0;
        waitResponse(lat, pc, fp);
        checkOutput("wr_penable_cycles", 32'(pc), 32'd3);
        checkOutput("wr_err",     32'(rsp_err),     32'h1);
        checkOutput("wr_timeout", 32'(rsp_timeout), 32'h0);
        checkOutput("wr_rdata",   rsp_rdata,        32'h0);
        @(posedge pclk); #1;

        // Decode error: region 5 is beyond the four completers
        applyStimulus(1'b0, 32'h0000_5000, 32'h0, wt);
        cmd_valid = 1'b0;
        waitResponse(lat, pc, fp);
        checkOutput("dec_latency", 32'(lat), 32'd1);
        checkOutput("dec_psel",    32'(fp),  32'h0);
        checkOutput("dec_err",     32'(rsp_err),     32'h1);
        checkOutput("dec_timeout", 32'(rsp_timeout), 32'h0);
        @(posedge pclk); #1;

        // One-wait read from completer 0
        wait_cfg[0] = 1; rdata_cfg[0] = 32'h0BAD_F00D;
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, wt);
        cmd_valid = 1'b0;
        waitResponse(lat, pc, fp);
        checkOutput("w1_latency", 32'(lat), 32'd4);
        checkOutput("w1_rdata",   rsp_rdata, 32'h0BAD_F00D);
        @(posedge pclk); #1;

        // Completer 2 never ready: abort after 16 ACCESS cycles
        wait_cfg[2] = 100;
        applyStimulus(1'b0, 32'h0000_2000, 32'h0, wt);
        cmd_valid = 1'b0;
        waitResponse(lat, pc, fp);
        checkOutput("to_latency",        32'(lat), 32'd18);
        checkOutput("to_penable_cycles", 32'(pc),  32'd16);
        checkOutput("to_err",     32'(rsp_err),     32'h1);
        checkOutput("to_timeout", 32'(rsp_timeout), 32'h1);
        @(posedge pclk); #1;
        checkOutput("to_psel_after", 32'(psel), 32'h0);

        // Back-to-back commands with cmd_valid held
        wait_cfg[0] = 0; err_cfg[0] = 1'b0;
        applyStimulus(1'b0, 32'h0000_3000, 32'h0, wt);
        applyStimulus(1'b1, 32'h0000_0010, 32'h0000_CAFE, wt);
        checkOutput("b2b_gap1", 32'(wt), 32'd3);
        applyStimulus(1'b0, 32'h0000_7000, 32'h0, wt);
        checkOutput("b2b_gap2", 32'(wt), 32'd3);
        cmd_valid = 1'b0;
        waitResponse(lat, pc, fp);
        checkOutput("b2b_dec_latency", 32'(lat), 32'd1);
        @(posedge pclk); #1;

        // Reset pulsed during ACCESS: outputs drop at once and no response follows
        wait_cfg[2] = 5;
        applyStimulus(1'b0, 32'h0000_2004, 32'h0, wt);
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        #2;
        preset = 1'b1;
        #1;
        checkOutput("rst_psel",      32'(psel),      32'h0);
        checkOutput("rst_penable",   32'(penable),   32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        checkOutput("rst_rsp_err",   32'(rsp_err),   32'h0);
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b0;
        nrsp = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge pclk);
            if (rsp_valid) nrsp++;
        end
        checkOutput("rst_no_response", 32'(nrsp), 32'h0);
        @(posedge pclk); #1;

        // Recovery: plain zero-wait read after reset
        applyStimulus(1'b0, 32'h0000_3000, 32'h0, wt);
        cmd_valid = 1'b0;
        waitResponse(lat, pc, fp);
        checkOutput("post_rst_latency", 32'(lat), 32'd3);
        checkOutput("post_rst_rdata",   rsp_rdata, 32'hA5A5_0001);
        repeat (3) @(posedge pclk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
